mod_keypad_scan: RTL

//  Input-side counterpart of the multiplexed 4-digit display driver. It strobes the

---
 rtl/mod_keypad_scan.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mod_keypad_scan.sv
// 4x4 hex keypad scanner: strobes one column at a time, debounces a press on the
// slow scan tick and hands each accepted key to the core over valid/ready.
module mod_keypad_scan #(
  parameter int SCAN_DIV_BITS  = 15,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_rows_n,
  output logic [3:0] o_cols_n,
  output logic [3:0] o_key,
  output logic       o_key_valid,
  input  logic       i_key_ready,
  output logic       o_key_down,
  output logic       o_overrun
);

  localparam logic [3:0]               DB_TARGET = 4'(DEBOUNCE_SCANS);
  localparam logic [SCAN_DIV_BITS-1:0] DIV_ONE   = SCAN_DIV_BITS'(1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t                   state;
  logic [SCAN_DIV_BITS-1:0] div_cnt;
  logic [3:0]               rows_meta;
  logic [3:0]               rows_s;
  logic [1:0]               col;
  logic [1:0]               row_lat;
  logic [3:0]               cnt;

  logic       tick;
  logic       hit;
  logic [1:0] sel_row;
  logic       emit;
  logic       transfer;

  assign tick     = &div_cnt;
  assign hit      = ~&rows_s;
  assign transfer = o_key_valid & i_key_ready;
  assign o_cols_n = ~(4'b0001 << col);

  // Lowest-index pressed row wins when several rows are low at once.
  always_comb begin
    sel_row = 2'd0;
    if (!rows_s[0])      sel_row = 2'd0;
    else if (!rows_s[1]) sel_row = 2'd1;
    else if (!rows_s[2]) sel_row = 2'd2;
    else if (!rows_s[3]) sel_row = 2'd3;
  end

  always_comb begin
    emit = 1'b0;
    if (tick && hit) begin
      if (state == SCAN)
        emit = (DB_TARGET == 4'd1);
      else if (state == DEBOUNCE)
        emit = (sel_row == row_lat) && ((cnt + 4'd1) == DB_TARGET);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= SCAN;
      div_cnt     <= '0;
      rows_meta   <= 4'b1111;
      rows_s      <= 4'b1111;
      col         <= 2'd0;
      row_lat     <= 2'd0;
      cnt         <= 4'd0;
      o_key       <= 4'd0;
      o_key_valid <= 1'b0;
      o_key_down  <= 1'b0;
      o_overrun   <= 1'b0;
    end else begin
      rows_meta <= i_rows_n;
      rows_s    <= rows_meta;
      div_cnt   <= div_cnt + DIV_ONE;

      if (tick) begin
        case (state)
          SCAN: begin
            if (hit) begin
              row_lat <= sel_row;
              if (emit) begin
                cnt        <= 4'd0;
                state      <= HELD;
                o_key_down <= 1'b1;
              end else begin
                cnt   <= 4'd1;
                state <= DEBOUNCE;
              end
            end else begin
              col <= col + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (hit && (sel_row == row_lat)) begin
              if (emit) begin
                cnt        <= 4'd0;
                state      <= HELD;
                o_key_down <= 1'b1;
              end else begin
                cnt <= cnt + 4'd1;
              end
            end else begin
              state <= SCAN;
              col   <= col + 2'd1;
            end
          end
          HELD: begin
            // Column stays frozen, so the latched row reads this exact key.
            if (!rows_s[row_lat]) begin
              cnt <= 4'd0;
            end else if ((cnt + 4'd1) == DB_TARGET) begin
              cnt        <= 4'd0;
              state      <= SCAN;
              o_key_down <= 1'b0;
              col        <= col + 2'd1;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
          default: begin
            state      <= SCAN;
            o_key_down <= 1'b0;
            cnt        <= 4'd0;
          end
        endcase
      end

      // A key arriving while the previous one is still pending is dropped.
      if (emit) begin
        if (!o_key_valid || i_key_ready) begin
          o_key       <= {sel_row, col};
          o_key_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (transfer) begin
        o_key_valid <= 1'b0;
      end

      if (transfer) o_overrun <= 1'b0;
    end
  end

endmodule
